// File: rtl/axis_width_pkg.sv
// Shared helpers for the AXI4-Stream width converters: sizing, lane placement
// and parameter legality.
package axis_width_pkg;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r++;
    return r;
  endfunction

  function automatic int unsigned keep_w(input int unsigned s_width);
    return s_width / 8;
  endfunction

  function automatic int unsigned m_width(input int unsigned s_width, input int unsigned ratio);
    return s_width * ratio;
  endfunction

  // Bit offset of lane `lane` in the wide word; order 1 puts lane 0 at the MSB end.
  function automatic int unsigned lane_offset(input int unsigned lane, input int unsigned ratio,
                                              input int unsigned width, input int unsigned order);
    return ((order != 0) ? (ratio - 1 - lane) : lane) * width;
  endfunction

  function automatic bit is_pow2(input int unsigned v);
    return (v != 0) && ((v & (v - 1)) == 0);
  endfunction

  function automatic bit params_legal(input int unsigned s_width, input int unsigned ratio);
    return (s_width != 0) && (s_width % 8 == 0) && is_pow2(ratio) && (ratio >= 2) && (ratio <= 16);
  endfunction

endpackage

// File: rtl/axis_upsizer_lane_acc.sv
// Lane accumulator for the upsizer: stores beats per lane and presents the
// merged wide word for the beat currently on the input.
module axis_upsizer_lane_acc
  import axis_width_pkg::*;
#(
  parameter int unsigned S_WIDTH    = 64,
  parameter int unsigned RATIO      = 8,
  parameter int unsigned LANE_ORDER = 0
) (
  input  logic                            aclk,
  input  logic                            aresetn,
  input  logic                            beat_en,
  input  logic [S_WIDTH-1:0]              s_data,
  input  logic [S_WIDTH/8-1:0]            s_keep,
  input  logic                            s_last,
  output logic                            complete,
  output logic [S_WIDTH*RATIO-1:0]        word_data,
  output logic [S_WIDTH*RATIO/8-1:0]      word_keep
);

  localparam int unsigned LANE_W = clog2(RATIO);
  localparam int unsigned KEEP_W = keep_w(S_WIDTH);

  logic [S_WIDTH-1:0] acc_data [RATIO];
  logic [KEEP_W-1:0]  acc_keep [RATIO];
  logic [LANE_W-1:0]  lane;

  assign complete = (lane == LANE_W'(RATIO - 1)) || s_last;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      lane <= '0;
      for (int unsigned i = 0; i < RATIO; i++) begin
        acc_data[i] <= '0;
        acc_keep[i] <= '0;
      end
    end else if (beat_en) begin
      if (complete) begin
        lane <= '0;
        for (int unsigned i = 0; i < RATIO; i++) acc_keep[i] <= '0;
      end else begin
        acc_data[lane] <= s_data;
        acc_keep[lane] <= s_keep;
        lane           <= lane + LANE_W'(1);
      end
    end
  end

  // Lanes above the current one may hold stale data from earlier words; they are masked here.
  always_comb begin
    word_data = '0;
    word_keep = '0;
    for (int unsigned i = 0; i < RATIO; i++) begin
      if (i < int'(lane)) begin
        word_data[lane_offset(i, RATIO, S_WIDTH, LANE_ORDER) +: S_WIDTH] = acc_data[i];
        word_keep[lane_offset(i, RATIO, KEEP_W, LANE_ORDER) +: KEEP_W]   = acc_keep[i];
      end else if (i == int'(lane)) begin
        word_data[lane_offset(i, RATIO, S_WIDTH, LANE_ORDER) +: S_WIDTH] = s_data;
        word_keep[lane_offset(i, RATIO, KEEP_W, LANE_ORDER) +: KEEP_W]   = s_keep;
      end
    end
  end

endmodule

// File: rtl/axis_upsizer.sv
// AXI4-Stream width upsizer: packs RATIO input beats into one wide output beat,
// flushing a masked partial word on TLAST.
module axis_upsizer
  import axis_width_pkg::*;
#(
  parameter int unsigned S_WIDTH    = 64,
  parameter int unsigned RATIO      = 8,
  parameter int unsigned LANE_ORDER = 0
) (
  input  logic                            aclk,
  input  logic                            aresetn,
  input  logic [S_WIDTH-1:0]              s_axis_tdata,
  input  logic [S_WIDTH/8-1:0]            s_axis_tkeep,
  input  logic                            s_axis_tvalid,
  input  logic                            s_axis_tlast,
  output logic                            s_axis_tready,
  output logic [S_WIDTH*RATIO-1:0]        m_axis_tdata,
  output logic [S_WIDTH*RATIO/8-1:0]      m_axis_tkeep,
  output logic                            m_axis_tvalid,
  output logic                            m_axis_tlast,
  input  logic                            m_axis_tready,
  output logic                            keep_err
);

  if (!params_legal(S_WIDTH, RATIO)) begin : g_bad_params
    $error("axis_upsizer: S_WIDTH must be a multiple of 8 and RATIO a power of two in 2..16");
  end

  logic                         accept;
  logic                         complete;
  logic [S_WIDTH*RATIO-1:0]     word_data;
  logic [S_WIDTH*RATIO/8-1:0]   word_keep;

  assign s_axis_tready = aresetn && (!m_axis_tvalid || m_axis_tready);
  assign accept        = s_axis_tvalid && s_axis_tready;

  axis_upsizer_lane_acc #(
    .S_WIDTH    (S_WIDTH),
    .RATIO      (RATIO),
    .LANE_ORDER (LANE_ORDER)
  ) u_lane_acc (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .beat_en   (accept),
    .s_data    (s_axis_tdata),
    .s_keep    (s_axis_tkeep),
    .s_last    (s_axis_tlast),
    .complete  (complete),
    .word_data (word_data),
    .word_keep (word_keep)
  );

  // Payload holds its last value after a transfer; only valid drops.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
    end else if (accept && complete) begin
      m_axis_tvalid <= 1'b1;
      m_axis_tlast  <= s_axis_tlast;
      m_axis_tdata  <= word_data;
      m_axis_tkeep  <= word_keep;
    end else if (m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      keep_err <= 1'b0;
    end else if (accept && !s_axis_tlast && (s_axis_tkeep != '1)) begin
      keep_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_axis_upsizer.sv
// Directed and randomised checks of axis_upsizer (64-bit x 8) in both lane orders.
module tb_axis_upsizer;

  localparam int unsigned SW  = 64;
  localparam int unsigned R   = 8;
  localparam int unsigned MW  = SW * R;
  localparam int unsigned MKW = MW / 8;

  logic            aclk = 1'b0;
  logic            aresetn;
  logic [SW-1:0]   s_tdata;
  logic [7:0]      s_tkeep;
  logic            s_tvalid;
  logic            s_tlast;
  logic            m_tready;
  logic            s_tready0, s_tready1;
  logic [MW-1:0]   m_tdata0, m_tdata1;
  logic [MKW-1:0]  m_tkeep0, m_tkeep1;
  logic            m_tvalid0, m_tvalid1, m_tlast0, m_tlast1;
  logic            keep_err0, keep_err1;

  always #5 aclk = ~aclk;

  axis_upsizer #(.S_WIDTH(SW), .RATIO(R), .LANE_ORDER(0)) dut0 (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
    .s_axis_tlast(s_tlast), .s_axis_tready(s_tready0),
    .m_axis_tdata(m_tdata0), .m_axis_tkeep(m_tkeep0), .m_axis_tvalid(m_tvalid0),
    .m_axis_tlast(m_tlast0), .m_axis_tready(m_tready), .keep_err(keep_err0)
  );

  axis_upsizer #(.S_WIDTH(SW), .RATIO(R), .LANE_ORDER(1)) dut1 (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
    .s_axis_tlast(s_tlast), .s_axis_tready(s_tready1),
    .m_axis_tdata(m_tdata1), .m_axis_tkeep(m_tkeep1), .m_axis_tvalid(m_tvalid1),
    .m_axis_tlast(m_tlast1), .m_axis_tready(m_tready), .keep_err(keep_err1)
  );

  typedef struct {
    logic [MW-1:0]  d0, d1;
    logic [MKW-1:0] k0, k1;
    logic           last;
  } word_t;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  word_t          exp_q[$];
  word_t          mon_w;
  logic [SW-1:0]  acc_d [R];
  logic [7:0]     acc_k [R];
  int unsigned    acc_n = 0;
  int unsigned    n_words = 0;
  int unsigned    cyc = 0;
  int unsigned    last_cyc = 0, prev_cyc = 0;
  logic [MW-1:0]  last_d0, last_d1;
  logic [MKW-1:0] last_k0, last_k1;
  logic           last_l;
  bit             rnd_valid = 0, rnd_ready = 0, ready_force = 1;

  task automatic check_eq(input string tag, input logic [MW-1:0] got, input logic [MW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge aclk) cyc <= cyc + 1;

  initial begin
    m_tready = 1'b0;
    forever begin
      @(posedge aclk);
      #2;
      m_tready = rnd_ready ? 1'($urandom_range(0, 1)) : ready_force;
    end
  end

  // Every completed output transfer is compared against the bench model.
  always @(negedge aclk) begin
    if (aresetn === 1'b1 && m_tvalid0 && m_tready) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_word", 512'(m_tvalid0), 512'(0));
      end else begin
        mon_w = exp_q.pop_front();
        check_eq("word_data_lo", m_tdata0, mon_w.d0);
        check_eq("word_data_hi", m_tdata1, mon_w.d1);
        check_eq("word_keep_lo", 512'(m_tkeep0), 512'(mon_w.k0));
        check_eq("word_keep_hi", 512'(m_tkeep1), 512'(mon_w.k1));
        check_eq("word_last_lo", 512'(m_tlast0), 512'(mon_w.last));
        check_eq("word_last_hi", 512'(m_tlast1), 512'(mon_w.last));
        check_eq("word_valid_hi", 512'(m_tvalid1), 512'(1));
        n_words++;
        last_d0 = m_tdata0; last_d1 = m_tdata1;
        last_k0 = m_tkeep0; last_k1 = m_tkeep1;
        last_l  = m_tlast0;
        prev_cyc = last_cyc;
        last_cyc = cyc;
      end
    end
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic model_emit(input logic last);
    word_t w;
    w.d0 = '0; w.d1 = '0; w.k0 = '0; w.k1 = '0; w.last = last;
    for (int i = 0; i <= int'(acc_n); i++) begin
      w.d0[i*SW +: SW]        = acc_d[i];
      w.k0[i*8 +: 8]          = acc_k[i];
      w.d1[MW-SW-i*SW +: SW]  = acc_d[i];
      w.k1[MKW-8-i*8 +: 8]    = acc_k[i];
    end
    exp_q.push_back(w);
  endtask

  task automatic send_beat(input logic [SW-1:0] d, input logic [7:0] k, input logic last);
    logic f;
    int unsigned waited;
    if (rnd_valid) begin
      while ($urandom_range(0, 1) == 1) begin
        s_tvalid = 1'b0;
        tick();
      end
    end
    s_tdata = d; s_tkeep = k; s_tlast = last; s_tvalid = 1'b1;
    f = 1'b0;
    waited = 0;
    while (!f && waited < 1000) begin
      @(negedge aclk);
      f = s_tready0;
      tick();
      waited++;
    end
    if (!f) begin
      check_eq("accept_timeout", 512'(f), 512'(1));
    end else begin
      acc_d[acc_n] = d;
      acc_k[acc_n] = k;
      if (acc_n == R - 1 || last) begin
        model_emit(last);
        acc_n = 0;
      end else begin
        acc_n++;
      end
    end
    s_tvalid = 1'b0;
  endtask

  task automatic drain();
    int unsigned n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      tick();
      n++;
    end
    tick();
    check_eq("drain_pending", 512'(exp_q.size()), 512'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [MW-1:0] ref_w;
    logic [MW-1:0] snap;
    int unsigned   n0;
    bit            held;
    int unsigned   len;

    aresetn = 1'b0;
    s_tdata = '0; s_tkeep = '0; s_tvalid = 1'b0; s_tlast = 1'b0;
    repeat (3) tick();
    check_eq("rst_s_tready", 512'(s_tready0), 512'(0));
    check_eq("rst_s_tready_hi", 512'(s_tready1), 512'(0));
    check_eq("rst_m_tvalid", 512'(m_tvalid0), 512'(0));
    check_eq("rst_m_tlast", 512'(m_tlast0), 512'(0));
    check_eq("rst_m_tdata", m_tdata0, 512'(0));
    check_eq("rst_m_tkeep", 512'(m_tkeep0), 512'(0));
    check_eq("rst_keep_err", 512'(keep_err0), 512'(0));
    aresetn = 1'b1;
    tick();

    // Two full words back to back, tlast on beat 15 only.
    n0 = n_words;
    for (int b = 0; b < 16; b++) send_beat(64'(b), 8'hFF, b == 15);
    drain();
    check_eq("two_words_count", 512'(n_words - n0), 512'(2));
    for (int i = 0; i < 8; i++) ref_w[i*SW +: SW] = 64'(8 + i);
    check_eq("word1_data", last_d0, ref_w);
    check_eq("word1_keep", 512'(last_k0), 512'(64'hFFFF_FFFF_FFFF_FFFF));
    check_eq("word1_last", 512'(last_l), 512'(1));
    check_eq("word_spacing", 512'(last_cyc - prev_cyc), 512'(8));

    // Three-beat packet: partial flush with upper lanes masked.
    send_beat(64'hAAAA_AAAA_AAAA_AAAA, 8'hFF, 1'b0);
    send_beat(64'hBBBB_BBBB_BBBB_BBBB, 8'hFF, 1'b0);
    send_beat(64'hCCCC_CCCC_CCCC_CCCC, 8'hFF, 1'b1);
    drain();
    check_eq("partial_keep", 512'(last_k0), 512'(64'h0000_0000_00FF_FFFF));
    check_eq("partial_data", last_d0,
             {320'h0, 64'hCCCC_CCCC_CCCC_CCCC, 64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA});
    check_eq("partial_last", 512'(last_l), 512'(1));

    // Output stall: five cycles of backpressure after the first word.
    n0 = n_words;
    for (int b = 0; b < 7; b++) send_beat(64'h100 + 64'(b), 8'hFF, 1'b0);
    ready_force = 1'b0;
    send_beat(64'h107, 8'hFF, 1'b0);
    snap = m_tdata0;
    for (int i = 0; i < 8; i++) ref_w[i*SW +: SW] = 64'h100 + 64'(i);
    check_eq("stall_word0", snap, ref_w);
    s_tdata = 64'h108; s_tkeep = 8'hFF; s_tlast = 1'b0; s_tvalid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      check_eq("stall_s_tready", 512'(s_tready0), 512'(0));
      check_eq("stall_valid", 512'(m_tvalid0), 512'(1));
      check_eq("stall_data", m_tdata0, snap);
      tick();
    end
    ready_force = 1'b1;
    for (int b = 8; b < 16; b++) send_beat(64'h100 + 64'(b), 8'hFF, b == 15);
    drain();
    for (int i = 0; i < 8; i++) ref_w[i*SW +: SW] = 64'h108 + 64'(i);
    check_eq("stall_word1", last_d0, ref_w);
    check_eq("stall_count", 512'(n_words - n0), 512'(2));

    // Random valid/ready, random packet lengths.
    rnd_valid = 1; rnd_ready = 1;
    for (int p = 0; p < 300; p++) begin
      len = $urandom_range(1, 40);
      for (int b = 0; b < int'(len); b++) begin
        if (b == int'(len) - 1)
          send_beat({$urandom, $urandom}, 8'($urandom_range(1, 255)), 1'b1);
        else
          send_beat({$urandom, $urandom}, 8'hFF, 1'b0);
      end
    end
    rnd_valid = 0; rnd_ready = 0;
    tick();
    drain();
    check_eq("rand_keep_err", 512'(keep_err0), 512'(0));
    check_eq("rand_keep_err_hi", 512'(keep_err1), 512'(0));

    // Sparse keep on a non-last beat sets the sticky error.
    send_beat(64'h11, 8'h0F, 1'b0);
    check_eq("keep_err_set", 512'(keep_err0), 512'(1));
    held = 1;
    repeat (100) begin
      tick();
      held &= keep_err0;
    end
    check_eq("keep_err_held", 512'(held), 512'(1));
    send_beat(64'h22, 8'h03, 1'b1);
    drain();
    check_eq("sparse_keep_lo", 512'(last_k0), 512'(64'h0000_0000_0000_030F));
    check_eq("sparse_keep_hi", 512'(last_k1), 512'(64'h0F03_0000_0000_0000));
    check_eq("sparse_data", 512'(last_d0[127:0]), 512'({64'h22, 64'h11}));

    // Reset mid-packet discards the partial word.
    n0 = n_words;
    for (int b = 0; b < 4; b++) send_beat(64'h300 + 64'(b), 8'hFF, 1'b0);
    aresetn = 1'b0;
    acc_n = 0;
    tick();
    check_eq("mid_rst_valid", 512'(m_tvalid0), 512'(0));
    check_eq("mid_rst_s_tready", 512'(s_tready0), 512'(0));
    tick();
    aresetn = 1'b1;
    tick();
    check_eq("mid_rst_no_word", 512'(n_words - n0), 512'(0));
    check_eq("mid_rst_keep_err", 512'(keep_err0), 512'(0));
    for (int b = 0; b < 8; b++) send_beat(64'h200 + 64'(b), 8'hFF, b == 7);
    drain();
    check_eq("post_rst_count", 512'(n_words - n0), 512'(1));
    check_eq("post_rst_lane0_lo", 512'(last_d0[63:0]), 512'(64'h200));
    check_eq("post_rst_lane0_hi", 512'(last_d1[511:448]), 512'(64'h200));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
